pc_unit: RTL and testbench

//  Parametrised program-counter unit for the MIPS single-cycle/pipelined core; successor to the plain PC register.

---
 rtl/pc_pkg.sv | 24 ++
 rtl/pc_if.sv | 26 ++
 rtl/pc_next_sel.sv | 58 +++++
 rtl/pc_unit.sv | 127 ++++++++++++
 tb/tb_pc_unit.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared types and default constants for the program-counter unit.
package pc_pkg;

    localparam int unsigned ADDR_W_DEF      = 32;
    localparam int unsigned INSTR_BYTES_DEF = 4;
    localparam logic [31:0] RESET_VEC_DEF   = 32'h0040_0000;
    localparam logic [31:0] EXC_VEC_DEF     = 32'h8000_0180;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } pc_state_e;

    // Action chosen by the next-PC selector for the coming edge.
    typedef enum logic [2:0] {
        SEL_KEEP = 3'd0,
        SEL_SEQ  = 3'd1,
        SEL_EXC  = 3'd2,
        SEL_LOAD = 3'd3,
        SEL_PEND = 3'd4
    } pc_sel_e;

endpackage

// File: rtl/pc_if.sv
// Control/fetch-side bus of the program-counter unit.
interface pc_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              stall_i;
    logic              br_valid_i;
    logic [ADDR_W-1:0] br_target_i;
    logic              eret_i;
    logic              exc_valid_i;
    logic [ADDR_W-1:0] exc_pc_i;
    logic [ADDR_W-1:0] pc_o;
    logic              pc_valid_o;
    logic [ADDR_W-1:0] epc_o;
    logic              redirect_o;
    logic              misalign_o;

    modport master (
        output stall_i, br_valid_i, br_target_i, eret_i, exc_valid_i, exc_pc_i,
        input  pc_o, pc_valid_o, epc_o, redirect_o, misalign_o
    );

    modport slave (
        input  stall_i, br_valid_i, br_target_i, eret_i, exc_valid_i, exc_pc_i,
        output pc_o, pc_valid_o, epc_o, redirect_o, misalign_o
    );
endinterface

// File: rtl/pc_next_sel.sv
// Priority selection of the next-PC action plus alignment check of the
// target that action would load or capture.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned INSTR_BYTES = INSTR_BYTES_DEF
) (
    input  pc_state_e         i_state,
    input  logic              i_stall,
    input  logic              i_br_valid,
    input  logic [ADDR_W-1:0] i_br_target,
    input  logic              i_eret,
    input  logic              i_exc_valid,
    input  logic [ADDR_W-1:0] i_epc,
    input  logic [ADDR_W-1:0] i_pend,
    output pc_sel_e           o_sel,
    output logic [ADDR_W-1:0] o_tgt,
    output logic              o_tgt_misalign
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INSTR_BYTES - 1);

    logic              w_redir;
    logic [ADDR_W-1:0] w_new_tgt;

    // eret outranks a simultaneous branch
    assign w_redir   = i_eret | i_br_valid;
    assign w_new_tgt = i_eret ? i_epc : i_br_target;

    always_comb begin
        o_sel = SEL_KEEP;
        o_tgt = w_new_tgt;
        unique case (i_state)
            ST_RUN: begin
                if (i_exc_valid)                o_sel = SEL_EXC;
                else if (i_stall && w_redir)    o_sel = SEL_PEND;
                else if (i_stall)               o_sel = SEL_KEEP;
                else if (w_redir)               o_sel = SEL_LOAD;
                else                            o_sel = SEL_SEQ;
            end
            ST_HOLD: begin
                if (i_exc_valid)                o_sel = SEL_EXC;
                else if (i_stall && w_redir)    o_sel = SEL_PEND;
                else if (i_stall)               o_sel = SEL_KEEP;
                else begin
                    // release edge: the buffered target wins, fresh br/eret dropped
                    o_sel = SEL_LOAD;
                    o_tgt = i_pend;
                end
            end
            default: o_sel = SEL_KEEP;
        endcase
    end

    assign o_tgt_misalign = |(o_tgt & ALIGN_MASK);

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC selection, stall hold with one pending
// redirect, EPC capture and misaligned-target trapping.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter logic [31:0] RESET_VEC   = RESET_VEC_DEF,
    parameter logic [31:0] EXC_VEC     = EXC_VEC_DEF,
    parameter int unsigned INSTR_BYTES = INSTR_BYTES_DEF
) (
    input  logic clk,
    input  logic reset,
    pc_if.slave  bus
);

    localparam logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_VEC);
    localparam logic [ADDR_W-1:0] EXC_PC   = ADDR_W'(EXC_VEC);
    localparam logic [ADDR_W-1:0] PC_INC   = ADDR_W'(INSTR_BYTES);

    pc_state_e         r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_epc;
    logic [ADDR_W-1:0] r_pend;
    logic              r_pc_valid;
    logic              r_redirect;
    logic              r_misalign;

    pc_state_e         w_state_nxt;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_epc_nxt;
    logic [ADDR_W-1:0] w_pend_nxt;
    logic              w_pc_valid_nxt;
    logic              w_redirect_nxt;
    logic              w_misalign_nxt;

    pc_sel_e           w_sel;
    logic [ADDR_W-1:0] w_tgt;
    logic              w_tgt_misalign;

    pc_next_sel #(
        .ADDR_W      (ADDR_W),
        .INSTR_BYTES (INSTR_BYTES)
    ) u_next_sel (
        .i_state        (r_state),
        .i_stall        (bus.stall_i),
        .i_br_valid     (bus.br_valid_i),
        .i_br_target    (bus.br_target_i),
        .i_eret         (bus.eret_i),
        .i_exc_valid    (bus.exc_valid_i),
        .i_epc          (r_epc),
        .i_pend         (r_pend),
        .o_sel          (w_sel),
        .o_tgt          (w_tgt),
        .o_tgt_misalign (w_tgt_misalign)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_PC;
            r_epc      <= '0;
            r_pend     <= '0;
            r_pc_valid <= 1'b0;
            r_redirect <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_epc      <= w_epc_nxt;
            r_pend     <= w_pend_nxt;
            r_pc_valid <= w_pc_valid_nxt;
            r_redirect <= w_redirect_nxt;
            r_misalign <= w_misalign_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_epc_nxt      = r_epc;
        w_pend_nxt     = r_pend;
        w_pc_valid_nxt = r_pc_valid;
        w_redirect_nxt = 1'b0;
        w_misalign_nxt = 1'b0;

        if (r_state == ST_BOOT) begin
            // first fetch is the reset vector itself
            w_state_nxt    = ST_RUN;
            w_pc_valid_nxt = 1'b1;
        end else begin
            unique case (w_sel)
                SEL_SEQ: w_pc_nxt = r_pc + PC_INC;
                SEL_EXC: begin
                    w_pc_nxt       = EXC_PC;
                    w_epc_nxt      = bus.exc_pc_i;
                    w_redirect_nxt = 1'b1;
                    w_pend_nxt     = '0;
                    w_state_nxt    = ST_RUN;
                end
                SEL_PEND: begin
                    w_pend_nxt  = w_tgt;
                    w_state_nxt = ST_HOLD;
                end
                SEL_LOAD: begin
                    w_redirect_nxt = 1'b1;
                    w_pend_nxt     = '0;
                    w_state_nxt    = ST_RUN;
                    if (w_tgt_misalign) begin
                        w_pc_nxt       = EXC_PC;
                        w_epc_nxt      = r_pc;
                        w_misalign_nxt = 1'b1;
                    end else begin
                        w_pc_nxt = w_tgt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.pc_o       = r_pc;
    assign bus.pc_valid_o = r_pc_valid;
    assign bus.epc_o      = r_epc;
    assign bus.redirect_o = r_redirect;
    assign bus.misalign_o = r_misalign;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit with hand-computed expectations.
module tb_pc_unit;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    pc_if #(.ADDR_W(32)) bus ();

    pc_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_checks++;
        if (got !== exp_v) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp_v);
        end
    endtask

    task automatic drive(input logic stall, input logic br, input logic [31:0] tgt,
                         input logic eret, input logic exc, input logic [31:0] excpc);
        bus.stall_i     = stall;
        bus.br_valid_i  = br;
        bus.br_target_i = tgt;
        bus.eret_i      = eret;
        bus.exc_valid_i = exc;
        bus.exc_pc_i    = excpc;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    // one rising edge, then settle to the falling edge for sampling/driving
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_state(input string tag, input logic [31:0] pc, input logic valid,
                               input logic redir, input logic mis);
        check({tag, ".pc"},    bus.pc_o, pc);
        check({tag, ".valid"}, 32'(bus.pc_valid_o), 32'(valid));
        check({tag, ".redir"}, 32'(bus.redirect_o), 32'(redir));
        check({tag, ".mis"},   32'(bus.misalign_o), 32'(mis));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b0;
        idle();
        @(negedge clk);
        @(negedge clk);

        // reset and boot sequence
        check_state("rst", 32'h0040_0000, 1'b0, 1'b0, 1'b0);
        check("rst.epc", bus.epc_o, 32'h0);
        reset = 1'b1;
        step(); check_state("boot", 32'h0040_0000, 1'b1, 1'b0, 1'b0);
        step(); check_state("seq1", 32'h0040_0004, 1'b1, 1'b0, 1'b0);
        step(); check_state("seq2", 32'h0040_0008, 1'b1, 1'b0, 1'b0);

        // taken branch
        drive(1'b0, 1'b1, 32'h0040_0100, 1'b0, 1'b0, 32'h0);
        step(); check_state("br", 32'h0040_0100, 1'b1, 1'b1, 1'b0);
        idle();
        step(); check_state("br.seq", 32'h0040_0104, 1'b1, 1'b0, 1'b0);

        // stall with two branches, youngest wins on release
        drive(1'b1, 1'b1, 32'h0040_0200, 1'b0, 1'b0, 32'h0);
        step(); check_state("st1", 32'h0040_0104, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 32'h0040_0300, 1'b0, 1'b0, 32'h0);
        step(); check_state("st2", 32'h0040_0104, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(); check_state("st3", 32'h0040_0104, 1'b1, 1'b0, 1'b0);
        idle();
        step(); check_state("st.rel", 32'h0040_0300, 1'b1, 1'b1, 1'b0);
        step(); check_state("st.seq", 32'h0040_0304, 1'b1, 1'b0, 1'b0);

        // exception overrides stall, then eret
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0040_0010);
        step(); check_state("exc", 32'h8000_0180, 1'b1, 1'b1, 1'b0);
        check("exc.epc", bus.epc_o, 32'h0040_0010);
        idle();
        step(); check_state("exc.seq", 32'h8000_0184, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        step(); check_state("eret", 32'h0040_0010, 1'b1, 1'b1, 1'b0);
        idle();
        step(); check_state("eret.seq", 32'h0040_0014, 1'b1, 1'b0, 1'b0);

        // misaligned branch traps
        drive(1'b0, 1'b1, 32'h0040_0102, 1'b0, 1'b0, 32'h0);
        step(); check_state("mis", 32'h8000_0180, 1'b1, 1'b1, 1'b1);
        check("mis.epc", bus.epc_o, 32'h0040_0014);
        idle();
        step(); check_state("mis.seq", 32'h8000_0184, 1'b1, 1'b0, 1'b0);

        // misaligned pending target: no trap on capture, trap on load
        drive(1'b1, 1'b1, 32'h0040_0006, 1'b0, 1'b0, 32'h0);
        step(); check_state("pmis.cap", 32'h8000_0184, 1'b1, 1'b0, 1'b0);
        idle();
        step(); check_state("pmis.ld", 32'h8000_0180, 1'b1, 1'b1, 1'b1);
        check("pmis.epc", bus.epc_o, 32'h8000_0184);

        // eret beats branch when both asserted
        drive(1'b0, 1'b1, 32'h0040_0400, 1'b1, 1'b0, 32'h0);
        step(); check_state("eret.br", 32'h8000_0184, 1'b1, 1'b1, 1'b0);
        idle();
        step(); check("eret.br.seq", bus.pc_o, 32'h8000_0188);

        // branch arriving on the release edge is dropped
        drive(1'b1, 1'b1, 32'h0040_0500, 1'b0, 1'b0, 32'h0);
        step(); check("drop.hold", bus.pc_o, 32'h8000_0188);
        drive(1'b0, 1'b1, 32'h0040_0600, 1'b0, 1'b0, 32'h0);
        step(); check_state("drop.rel", 32'h0040_0500, 1'b1, 1'b1, 1'b0);
        idle();
        step(); check("drop.seq", bus.pc_o, 32'h0040_0504);

        // exception in HOLD discards pending target
        drive(1'b1, 1'b1, 32'h0040_0700, 1'b0, 1'b0, 32'h0);
        step(); check("hexc.hold", bus.pc_o, 32'h0040_0504);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0040_0ABC);
        step(); check_state("hexc", 32'h8000_0180, 1'b1, 1'b1, 1'b0);
        check("hexc.epc", bus.epc_o, 32'h0040_0ABC);
        idle();
        step(); check_state("hexc.seq", 32'h8000_0184, 1'b1, 1'b0, 1'b0);

        // wrap at the top of the address space
        drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
        step(); check("wrap.top", bus.pc_o, 32'hFFFF_FFFC);
        idle();
        step(); check_state("wrap", 32'h0000_0000, 1'b1, 1'b0, 1'b0);

        // asynchronous reset while holding a pending redirect
        drive(1'b1, 1'b1, 32'h0040_0800, 1'b0, 1'b0, 32'h0);
        step(); check("rh.hold", bus.pc_o, 32'h0000_0000);
        reset = 1'b0;
        #1;
        check_state("rh.rst", 32'h0040_0000, 1'b0, 1'b0, 1'b0);
        check("rh.epc", bus.epc_o, 32'h0);
        idle();
        @(negedge clk);
        reset = 1'b1;
        step(); check_state("rh.boot", 32'h0040_0000, 1'b1, 1'b0, 1'b0);
        step(); check_state("rh.seq", 32'h0040_0004, 1'b1, 1'b0, 1'b0);
        step(); check_state("rh.seq2", 32'h0040_0008, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
